// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader
//   Loads the configuration of the LUT fabric from a byte-serial frame.
//   The frame is HEADER, then 3 bytes per LUT, then an XOR checksum. It is
//   staged in a shadow store and copied to the active outputs in one step,
//   and only when the header and the checksum are both good.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_data/in_valid       configuration byte stream
//   in_ready               byte accepted when in_valid && in_ready (state only)
//   cfg_abort              drop the frame being received (LOAD/CHECK only)
//   lut_truth              active truth tables, LUT i at [16i+15:16i]
//   lut_sel                active input selects, LUT i at [8i+7:8i]
//   cfg_busy               registered, high while a frame is in progress
//   cfg_done / cfg_err     one-cycle pulses: commit, or header/checksum failure
module lut_cfg_loader #(
    parameter int          NUM_LUTS = 16,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    cfg_abort,
    output logic [NUM_LUTS*16-1:0]  lut_truth,
    output logic [NUM_LUTS*8-1:0]   lut_sel,
    output logic                    cfg_busy,
    output logic                    cfg_done,
    output logic                    cfg_err
);
    localparam int NBYTES = 3 * NUM_LUTS;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, COMMIT, FAIL} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       xsum;
    logic [7:0]       shadow [NBYTES];
    logic             xfer;
    logic             hdr_bad;

    assign in_ready = (state == IDLE) || (state == LOAD) || (state == CHECK);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_n = state;
        hdr_bad = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (in_data == HEADER) state_n = LOAD;
                    else                   hdr_bad = 1'b1;
                end
            end
            LOAD: begin
                if (cfg_abort)                  state_n = IDLE;
                else if (xfer && cnt == LAST)   state_n = CHECK;
            end
            CHECK: begin
                if (cfg_abort)  state_n = IDLE;
                else if (xfer)  state_n = (in_data == xsum) ? COMMIT : FAIL;
            end
            COMMIT:  state_n = IDLE;
            FAIL:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Control state, byte counter, running checksum and the status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            xsum     <= '0;
            cfg_busy <= 1'b0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_n;
            // Registered copy of "state != IDLE" so it lines up with state.
            cfg_busy <= (state_n != IDLE);
            cfg_done <= (state == COMMIT);
            cfg_err  <= (state == FAIL) || hdr_bad;
            case (state)
                IDLE: begin
                    if (xfer && in_data == HEADER) begin
                        cnt  <= '0;
                        xsum <= '0;
                    end
                end
                LOAD: begin
                    if (cfg_abort) begin
                        cnt  <= '0;
                        xsum <= '0;
                    end else if (xfer) begin
                        cnt  <= cnt + 1'b1;
                        xsum <= xsum ^ in_data;
                    end
                end
                CHECK: begin
                    if (cfg_abort) begin
                        cnt  <= '0;
                        xsum <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Shadow store: written only by un-aborted payload bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBYTES; i++) shadow[i] <= '0;
        end else if (state == LOAD && xfer && !cfg_abort) begin
            shadow[cnt] <= in_data;
        end
    end

    // Active configuration: every LUT loads from shadow on the same edge,
    // so the fabric never sees a partly updated configuration.
    for (genvar g = 0; g < NUM_LUTS; g++) begin : g_lut
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lut_truth[16*g +: 16] <= '0;
                lut_sel[8*g +: 8]     <= '0;
            end else if (state == COMMIT) begin
                lut_truth[16*g +: 16] <= {shadow[3*g+1], shadow[3*g]};
                lut_sel[8*g +: 8]     <= shadow[3*g+2];
            end
        end
    end

endmodule

// File: tb/tb_lut_cfg_loader.sv
module tb_lut_cfg_loader;
    localparam int N = 16;

    logic           clk = 1'b0;
    bit             clk_en = 1'b0;
    logic           rst_n;
    logic [7:0]     in_data;
    logic           in_valid;
    logic           in_ready;
    logic           cfg_abort;
    logic [N*16-1:0] lut_truth;
    logic [N*8-1:0]  lut_sel;
    logic           cfg_busy, cfg_done, cfg_err;

    int total = 0;
    int passed = 0;
    int busy_cnt = 0, done_cnt = 0, err_cnt = 0;
    int b0, d0, e0;

    lut_cfg_loader #(.NUM_LUTS(N), .HEADER(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .cfg_abort(cfg_abort), .lut_truth(lut_truth),
        .lut_sel(lut_sel), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .cfg_err(cfg_err)
    );

    always #5 if (clk_en) clk = ~clk;

    always @(negedge clk) begin
        if (cfg_busy) busy_cnt++;
        if (cfg_done) done_cnt++;
        if (cfg_err)  err_cnt++;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [N*16-1:0] exp_truth(input logic [7:0] k);
        logic [N*16-1:0] t;
        for (int i = 0; i < N; i++) t[16*i +: 16] = {8'h5A, 8'(i) ^ k};
        return t;
    endfunction

    function automatic logic [7:0] pay(input int n, input logic [7:0] k);
        case (n % 3)
            0:       return 8'(n / 3) ^ k;
            1:       return 8'h5A;
            default: return 8'hE4;
        endcase
    endfunction

    // Drive a byte at the negedge; it transfers on the following posedge.
    task automatic send(input logic [7:0] b);
        int g = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) chk("ready_timeout", in_ready, 1'b1);
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] k, input logic [7:0] cs, input bit stall);
        send(8'hA5);
        for (int n = 0; n < 3*N; n++) begin
            send(pay(n, k));
            if (stall && (n % 5) == 4) begin
                in_valid = 1'b0;
                repeat (3) @(negedge clk);
            end
        end
        send(cs);
        in_valid = 1'b0;
    endtask

    // Called one negedge after the checksum edge T.
    task automatic expect_commit(input string tag, input logic [7:0] k);
        chk({tag, "_done_early"}, cfg_done, 1'b0);
        @(negedge clk);
        chk({tag, "_done"}, cfg_done, 1'b1);
        chk({tag, "_truth"}, lut_truth, exp_truth(k));
        chk({tag, "_sel"}, lut_sel, {N{8'hE4}});
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; cfg_abort = 1'b0;

        // Reset with no clock running
        #20;
        chk("rst_truth", lut_truth, '0);
        chk("rst_sel", lut_sel, '0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_busy", cfg_busy, 1'b0);
        chk("rst_done", cfg_done, 1'b0);
        chk("rst_err", cfg_err, 1'b0);
        rst_n = 1'b1;
        #3 clk_en = 1'b1;
        @(negedge clk);

        // Good frame, full throughput
        b0 = busy_cnt;
        send_frame(8'h00, 8'h00, 1'b0);
        chk("good_busy_T", cfg_busy, 1'b1);
        chk("good_ready_T", in_ready, 1'b0);
        chk("good_truth_T", lut_truth, '0);
        expect_commit("good", 8'h00);
        chk("good_busy_span", busy_cnt - b0, 50);
        chk("good_ready_after", in_ready, 1'b1);

        // Bad checksum: outputs hold
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h30, 8'h01, 1'b0);
        chk("badcs_err_early", cfg_err, 1'b0);
        @(negedge clk);
        chk("badcs_err", cfg_err, 1'b1);
        chk("badcs_truth", lut_truth, exp_truth(8'h00));
        @(negedge clk);
        chk("badcs_done_cnt", done_cnt - d0, 0);
        chk("badcs_err_cnt", err_cnt - e0, 1);

        // Bad header, then a good frame
        send(8'h3C);
        in_valid = 1'b0;
        chk("badhdr_err", cfg_err, 1'b1);
        chk("badhdr_busy", cfg_busy, 1'b0);
        @(negedge clk);
        chk("badhdr_err_gone", cfg_err, 1'b0);
        send_frame(8'h30, 8'h00, 1'b0);
        expect_commit("after_badhdr", 8'h30);

        // Abort after 20 payload bytes
        d0 = done_cnt; e0 = err_cnt;
        send(8'hA5);
        for (int n = 0; n < 20; n++) send(pay(n, 8'h00));
        cfg_abort = 1'b1;
        send(8'hFF);
        cfg_abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_busy", cfg_busy, 1'b0);
        @(negedge clk);
        chk("abort_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        chk("abort_truth", lut_truth, exp_truth(8'h30));
        send_frame(8'h00, 8'h00, 1'b0);
        expect_commit("after_abort", 8'h00);

        // Stalled frame
        send_frame(8'h30, 8'h00, 1'b1);
        expect_commit("stall", 8'h30);

        // Reset mid-frame
        send(8'hA5);
        for (int n = 0; n < 30; n++) send(pay(n, 8'h00));
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_truth", lut_truth, '0);
        chk("midrst_sel", lut_sel, '0);
        chk("midrst_busy", cfg_busy, 1'b0);
        chk("midrst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(8'h00, 8'h00, 1'b0);
        expect_commit("after_rst", 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end
endmodule
